// File: rtl/gate_pipe.sv
// gate_pipe: per-beat bitwise gate (AND..PASSA) on WIDTH-bit operands,
// carried through DEPTH elastic valid/ready stages with a transfer count.
// Ports: clk, rst_n (async low), in_valid/in_ready/op/a/b upstream,
// out_valid/out_ready/y/out_op downstream, xfer_cnt output transfers.
// Macro GATE_PIPE_PARITY_EN adds output parity = ^y, staged with y.
module gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       out_op,
`ifdef GATE_PIPE_PARITY_EN
  output logic             parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("gate_pipe: WIDTH %0d not in 1..64", WIDTH);
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("gate_pipe: DEPTH %0d not in 1..4", DEPTH);
  end

  logic [WIDTH-1:0] f;

  always_comb begin
    f = '0;
    unique case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = ~(a & b);
      3'd3: f = ~(a | b);
      3'd4: f = a ^ b;
      3'd5: f = ~(a ^ b);
      3'd6: f = ~a;
      3'd7: f = a;
    endcase
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] yr     [DEPTH];
  logic [WIDTH-1:0] src_y  [DEPTH];
  logic [2:0]       opr    [DEPTH];
  logic [2:0]       src_op [DEPTH];
  logic             full;

  // Flattened form of en[i] = !v[i] | en[i+1]: a stage may load
  // unless it and every stage after it is full and out_ready is low.
  always_comb begin
    en   = '0;
    full = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        full = full & v[j];
      end
      en[i] = !full | out_ready;
    end
  end

  // Stage i loads from source i: the input for 0, stage i-1 otherwise.
  always_comb begin
    src_v     = DEPTH'({v, in_valid});
    src_y[0]  = f;
    src_op[0] = op;
    for (int i = 1; i < DEPTH; i++) begin
      src_y[i]  = yr[i-1];
      src_op[i] = opr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        yr[i]  <= '0;
        opr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          v[i]   <= src_v[i];
          yr[i]  <= src_y[i];
          opr[i] <= src_op[i];
        end
      end
    end
  end

`ifdef GATE_PIPE_PARITY_EN
  logic [DEPTH-1:0] pr;
  logic [DEPTH-1:0] src_p;

  assign src_p = DEPTH'({pr, ^f});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) pr[i] <= src_p[i];
      end
    end
  end

  assign parity = pr[DEPTH-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[DEPTH-1];
  assign y         = yr[DEPTH-1];
  assign out_op    = opr[DEPTH-1];

endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: scoreboard bench for gate_pipe in three configurations
// (8/2/16, 1/1/16, 8/3/4); parity checks when GATE_PIPE_PARITY_EN set.
module tb_gate_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  logic       iv0, ir0, ov0, or0;
  logic [2:0] op0, oop0;
  logic [7:0] a0, b0, y0;
  logic [15:0] xc0;
  logic       iv1, ir1, ov1, or1;
  logic [2:0] op1, oop1;
  logic       a1, b1, y1;
  logic [15:0] xc1;
  logic       iv2, ir2, ov2, or2;
  logic [2:0] op2, oop2;
  logic [7:0] a2, b2, y2;
  logic [3:0] xc2;
`ifdef GATE_PIPE_PARITY_EN
  logic p0, p1, p2;
`endif

  gate_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0), .op(op0),
    .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0),
    .y(y0), .out_op(oop0),
`ifdef GATE_PIPE_PARITY_EN
    .parity(p0),
`endif
    .xfer_cnt(xc0)
  );

  gate_pipe #(.WIDTH(1), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .op(op1),
    .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1),
    .y(y1), .out_op(oop1),
`ifdef GATE_PIPE_PARITY_EN
    .parity(p1),
`endif
    .xfer_cnt(xc1)
  );

  gate_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2), .op(op2),
    .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2),
    .y(y2), .out_op(oop2),
`ifdef GATE_PIPE_PARITY_EN
    .parity(p2),
`endif
    .xfer_cnt(xc2)
  );

  // entries: {parity, op, y}
  logic [11:0] sb0 [$];
  int          lat0 [$];
  logic [0:0]  sb1 [$];
  int          lat1 [$];
  logic [7:0]  sb2 [$];

  function automatic logic [7:0] ref_gate(
    input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ov0 !== 1'b0 || y0 !== 8'h00 || oop0 !== 3'd0)
      $display("FAIL rst_out0: got v=%b y=%h op=%0d want 0 0 0",
               ov0, y0, oop0);
    else n_pass++;
    n_chk++;
    if (xc0 !== 16'd0 || ir0 !== 1'b1)
      $display("FAIL rst_cnt_rdy0: got cnt=%0d rdy=%b want 0 1",
               xc0, ir0);
    else n_pass++;
    n_chk++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1 || ov2 !== 1'b0 || ir2 !== 1'b1
        || xc2 !== 4'd0)
      $display("FAIL rst_other: got v1=%b r1=%b v2=%b r2=%b c2=%0d",
               ov1, ir1, ov2, ir2, xc2);
    else n_pass++;
`ifdef GATE_PIPE_PARITY_EN
    n_chk++;
    if (p0 !== 1'b0)
      $display("FAIL rst_parity: got %b want 0", p0);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth();
    logic [7:0]  tbl [8];
    logic [11:0] e;
    int k = 0, got = 0, l;
    tbl = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    sb0 = {};
    lat0 = {};
    for (int t = 0; t < 40 && got < 8; t++) begin
      iv0 = (k < 8);
      op0 = 3'(k);
      a0 = 8'hF0;
      b0 = 8'hCC;
      or0 = 1'b1;
      #1;
      if (iv0 && ir0) begin
        sb0.push_back({1'b0, op0, tbl[k]});
        lat0.push_back(cyc);
        k++;
      end
      if (ov0 && or0 && sb0.size() > 0) begin
        e = sb0.pop_front();
        l = lat0.pop_front();
        n_chk++;
        if (y0 !== e[7:0])
          $display("FAIL truth_y%0d: got %h want %h", got, y0, e[7:0]);
        else n_pass++;
        n_chk++;
        if (oop0 !== e[10:8])
          $display("FAIL truth_op%0d: got %0d want %0d",
                   got, oop0, e[10:8]);
        else n_pass++;
        n_chk++;
        if (cyc - l !== 2)
          $display("FAIL truth_lat%0d: got %0d want 2", got, cyc - l);
        else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    iv0 = 1'b0;
    n_chk++;
    if (got !== 8) $display("FAIL truth_count: got %0d want 8", got);
    else n_pass++;
    n_chk++;
    if (xc0 !== 16'd8) $display("FAIL truth_xfer: got %0d want 8", xc0);
    else n_pass++;
  endtask

  task automatic test_nor();
    logic ta [4], tb [4], ty [4];
    logic e;
    int k = 0, got = 0, l;
    ta = '{1'b0, 1'b1, 1'b0, 1'b1};
    tb = '{1'b0, 1'b0, 1'b1, 1'b1};
    ty = '{1'b1, 1'b0, 1'b0, 1'b0};
    sb1 = {};
    lat1 = {};
    for (int t = 0; t < 20 && got < 4; t++) begin
      iv1 = (k < 4);
      op1 = 3'd3;
      a1 = (k < 4) ? ta[k] : 1'b0;
      b1 = (k < 4) ? tb[k] : 1'b0;
      or1 = 1'b1;
      #1;
      if (iv1 && ir1) begin
        sb1.push_back(ty[k]);
        lat1.push_back(cyc);
        k++;
      end
      if (ov1 && or1 && sb1.size() > 0) begin
        e = sb1.pop_front();
        l = lat1.pop_front();
        n_chk++;
        if (y1 !== e || cyc - l !== 1)
          $display("FAIL nor%0d: got y=%b lat=%0d want y=%b lat=1",
                   got, y1, cyc - l, e);
        else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    iv1 = 1'b0;
    n_chk++;
    if (got !== 4 || xc1 !== 16'd4)
      $display("FAIL nor_count: got %0d/%0d want 4/4", got, xc1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    int k = 0, got = 0;
    sb2 = {};
    op2 = 3'd7;
    b2 = 8'h00;
    or2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      iv2 = (k < 4);
      a2 = 8'(k + 1);
      #1;
      if (ov2) begin
        n_chk++;
        if (y2 !== 8'd1 || oop2 !== 3'd7)
          $display("FAIL bp_hold%0d: got y=%h op=%0d want 01 7",
                   c, y2, oop2);
        else n_pass++;
      end
      if (iv2 && ir2) begin
        sb2.push_back(a2);
        k++;
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (k !== 3 || ir2 !== 1'b0 || ov2 !== 1'b1)
      $display("FAIL bp_full: got acc=%0d rdy=%b v=%b want 3 0 1",
               k, ir2, ov2);
    else n_pass++;
    @(negedge clk);
    for (int t = 0; t < 20 && got < 4; t++) begin
      iv2 = (k < 4);
      a2 = 8'(k + 1);
      or2 = 1'b1;
      #1;
      if (t == 0) begin
        n_chk++;
        if (ir2 !== 1'b1 || ov2 !== 1'b1 || y2 !== 8'd1)
          $display("FAIL bp_simul: got rdy=%b v=%b y=%h want 1 1 01",
                   ir2, ov2, y2);
        else n_pass++;
      end
      if (iv2 && ir2) begin
        sb2.push_back(a2);
        k++;
      end
      if (ov2 && or2 && sb2.size() > 0) begin
        e = sb2.pop_front();
        n_chk++;
        if (y2 !== e)
          $display("FAIL bp_order%0d: got %h want %h", got, y2, e);
        else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    iv2 = 1'b0;
    n_chk++;
    if (got !== 4 || xc2 !== 4'd4)
      $display("FAIL bp_count: got %0d cnt=%0d want 4 4", got, xc2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [7:0]  r, hy;
    logic [2:0]  hop;
    logic        hv = 1'b0;
    int n = 0, base, bad = 0;
    base = int'(xc0);
    sb0 = {};
    for (int c = 0; c < 10000; c++) begin
      iv0 = 1'($urandom_range(0, 1));
      or0 = 1'($urandom_range(0, 1));
      op0 = 3'($urandom);
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      #1;
      if (hv) begin
        n_chk++;
        if (ov0 !== 1'b1 || y0 !== hy || oop0 !== hop)
          $display("FAIL rand_hold@%0d: got v=%b y=%h op=%0d want 1 %h %0d",
                   c, ov0, y0, oop0, hy, hop);
        else n_pass++;
      end
      if (iv0 && ir0) begin
        r = ref_gate(op0, a0, b0);
        sb0.push_back({^r, op0, r});
      end
      if (ov0 && or0) begin
        n_chk++;
        if (sb0.size() == 0) begin
          $display("FAIL rand_extra@%0d: got beat y=%h want none", c, y0);
        end else begin
          e = sb0.pop_front();
          if (y0 !== e[7:0] || oop0 !== e[10:8])
            $display("FAIL rand_data@%0d: got %h/%0d want %h/%0d",
                     c, y0, oop0, e[7:0], e[10:8]);
          else n_pass++;
`ifdef GATE_PIPE_PARITY_EN
          n_chk++;
          if (p0 !== e[11])
            $display("FAIL rand_par@%0d: got %b want %b", c, p0, e[11]);
          else n_pass++;
`endif
        end
        n++;
      end
      hv = ov0 && !or0;
      hy = y0;
      hop = oop0;
      @(negedge clk);
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    for (int t = 0; t < 10 && sb0.size() > 0; t++) begin
      #1;
      if (ov0) begin
        e = sb0.pop_front();
        n_chk++;
        if (y0 !== e[7:0])
          $display("FAIL rand_drain_data: got %h want %h", y0, e[7:0]);
        else n_pass++;
        n++;
      end else bad++;
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (sb0.size() != 0 || ov0 !== 1'b0 || bad != 0)
      $display("FAIL rand_drain: got left=%0d v=%b gaps=%0d want 0 0 0",
               sb0.size(), ov0, bad);
    else n_pass++;
    n_chk++;
    if (xc0 !== 16'(base + n))
      $display("FAIL rand_xfer: got %0d want %0d", xc0, 16'(base + n));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k = 0, got = 0, l;
    iv0 = 1'b1;
    or0 = 1'b0;
    op0 = 3'd0;
    a0 = 8'hFF;
    b0 = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    #1;
    n_chk++;
    if (ov0 !== 1'b1) $display("FAIL mid_pre: got v=%b want 1", ov0);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ov0 !== 1'b0 || y0 !== 8'h00 || xc0 !== 16'd0 || ir0 !== 1'b1)
      $display("FAIL mid_rst: got v=%b y=%h cnt=%0d rdy=%b want 0 00 0 1",
               ov0, y0, xc0, ir0);
    else n_pass++;
    n_chk++;
    if (xc2 !== 4'd0) $display("FAIL mid_rst2: got %0d want 0", xc2);
    else n_pass++;
    #3 rst_n = 1'b1;
    lat0 = {};
    for (int t = 0; t < 6; t++) begin
      iv0 = (k < 1);
      op0 = 3'd6;
      a0 = 8'hAA;
      b0 = 8'h00;
      or0 = 1'b1;
      #1;
      if (iv0 && ir0) begin
        lat0.push_back(cyc);
        k++;
      end
      if (ov0) begin
        n_chk++;
        if (lat0.size() == 0) begin
          $display("FAIL mid_extra: got y=%h want none", y0);
        end else begin
          l = lat0.pop_front();
          if (y0 !== 8'h55 || oop0 !== 3'd6 || cyc - l !== 2)
            $display("FAIL mid_beat: got %h/%0d lat=%0d want 55/6 lat=2",
                     y0, oop0, cyc - l);
          else n_pass++;
        end
        got++;
      end
      @(negedge clk);
    end
    iv0 = 1'b0;
    n_chk++;
    if (got !== 1) $display("FAIL mid_count: got %0d want 1", got);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    int k = 0, got = 0;
    sb2 = {};
    op2 = 3'd7;
    b2 = 8'h00;
    n_chk++;
    if (xc2 !== 4'd0) $display("FAIL wrap_start: got %0d want 0", xc2);
    else n_pass++;
    for (int t = 0; t < 40 && got < 17; t++) begin
      iv2 = (k < 17);
      a2 = 8'(k + 8'h30);
      or2 = 1'b1;
      #1;
      if (iv2 && ir2) begin
        sb2.push_back(a2);
        k++;
      end
      if (ov2 && or2 && sb2.size() > 0) begin
        e = sb2.pop_front();
        n_chk++;
        if (y2 !== e) $display("FAIL wrap_data%0d: got %h want %h",
                               got, y2, e);
        else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    iv2 = 1'b0;
    n_chk++;
    if (got !== 17 || xc2 !== 4'd1)
      $display("FAIL wrap_cnt: got %0d xfers cnt=%0d want 17 1",
               got, xc2);
    else n_pass++;
  endtask

`ifdef GATE_PIPE_PARITY_EN
  task automatic test_parity();
    logic [7:0] va [2];
    logic       vp [2];
    int k = 0, got = 0;
    va = '{8'h07, 8'h03};
    vp = '{1'b1, 1'b0};
    for (int t = 0; t < 10 && got < 2; t++) begin
      iv0 = (k < 2);
      op0 = 3'd7;
      a0 = (k < 2) ? va[k] : 8'h00;
      b0 = 8'h00;
      or0 = 1'b1;
      #1;
      if (iv0 && ir0) k++;
      if (ov0) begin
        n_chk++;
        if (got > 1 || y0 !== va[got] || p0 !== vp[got])
          $display("FAIL parity%0d: got y=%h p=%b", got, y0, p0);
        else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    iv0 = 1'b0;
    n_chk++;
    if (got !== 2) $display("FAIL parity_count: got %0d want 2", got);
    else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {iv0, or0, op0, a0, b0} = '0;
    {iv1, or1, op1, a1, b1} = '0;
    {iv2, or2, op2, a2, b2} = '0;
    test_reset();
    test_truth();
    test_nor();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
`ifdef GATE_PIPE_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_pipe.md
Name: gate_pipe

Overview:
- Parametrised, pipelined successor to the 2-input NOR gate.
- Applies one of eight bitwise two-operand gate functions, chosen per transaction, to WIDTH-bit operands.
- Result passes through a DEPTH-stage elastic pipeline with valid/ready handshake on both sides and a running transfer counter.
- Serves as the reusable registered logic primitive for datapath exercises and for gate-level testbench reuse.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 1..64.
- DEPTH, 2: number of register stages; legal range 1..4.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- op  input  3  function select, sampled with the beat
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- y  output  WIDTH  result
- out_op  output  3  op code carried with the result
- xfer_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Op encoding:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NAND: ~(a&b)
  - 3 NOR: ~(a|b)
  - 4 XOR: a^b
  - 5 XNOR: ~(a^b)
  - 6 NOTA: ~a; b ignored
  - 7 PASSA: a; b ignored
- Function is computed combinationally before stage 0. Every stage registers {valid, y, op}.
- Stage enable:
  - en[DEPTH-1] = !v[DEPTH-1] | out_ready
  - en[i] = !v[i] | en[i+1]
  - in_ready = en[0]. The combinational ready path through the chain is intended. There is no bubble penalty.
- Stage i loads when en[i] is high:
  - Stage 0 loads v = in_valid, and y/op from the input.
  - Stage i>0 loads from stage i-1.
  - A stage with en low holds all its contents.
- out_valid = v[DEPTH-1]. y and out_op come from the last stage.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+DEPTH when out_ready is held high.
- Throughput: one beat per cycle sustained.
- Transfer definitions:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Data integrity:
  - In-order delivery.
  - No beat is dropped or duplicated.
  - Capacity is DEPTH beats in flight.
- Backpressure: with out_ready low, the pipeline fills. in_ready drops only once all DEPTH stages are valid.
- Simultaneous events: when the pipeline is full and out_ready rises, in_ready is high in the same cycle, so a new beat enters while the oldest leaves.
- Data held while stalled: y and out_op remain stable while out_valid=1 and out_ready=0.
- Unused data: data registers when v=0 are don't-care, but must not be X-propagating into out_valid.
- xfer_cnt:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 without a flag.
- Reset:
  - rst_n low asynchronously clears all v, all y and op registers, and xfer_cnt to 0.
  - Outputs during reset: out_valid=0, y=0, out_op=0, xfer_cnt=0.
  - in_ready=1 while rst_n is low.
  - Reset mid-stream discards in-flight beats. The first beat after release appears after DEPTH cycles.
- Elaboration: illegal WIDTH or DEPTH triggers $error at elaboration.

Optional Feature:
- Macro: GATE_PIPE_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = ^y, computed before stage 0 and carried through the pipeline aligned with y.
  - Reset value 0; held on stall like y.
- Undefined: port absent, no parity logic. All other behaviour is identical.

Test Plan:
- Truth table: WIDTH=8, DEPTH=2, out_ready=1; drive a=8'hF0, b=8'hCC with op 0..7, one per cycle. Required y sequence, starting cycle t+2: C0, FC, 3F, 03, 3C, C3, 0F, F0. out_op matches each beat. xfer_cnt=8 at the end.
- NOR legacy equivalence: WIDTH=1, DEPTH=1, op=3; apply (a,b) = 00, 10, 01, 11. Required y = 1, 0, 0, 0, each one cycle after acceptance.
- Backpressure: DEPTH=3, out_ready=0; stream a=1,2,3,4 with op=7. Required: in_ready low after 3 acceptances, and y=1 held stable. Then raise out_ready: outputs 1,2,3,4 in order, no loss, and beat 4 is accepted in the same cycle beat 1 leaves.
- Random stall: random in_valid and out_ready for 10k cycles against a scoreboard. Required: zero mismatches and xfer_cnt equal to the scoreboard count.
- Reset mid-stream: two beats in flight, pulse rst_n low for half a cycle. Required: out_valid=0, y=0 and xfer_cnt=0 immediately. A new beat a=8'hAA, op=6 yields y=8'h55 after DEPTH cycles.
- Wrap and parity: CNT_W=4; complete 17 output transfers → xfer_cnt=1. With GATE_PIPE_PARITY_EN defined, y=8'h07 → parity=1 and y=8'h03 → parity=0.
